// File: rtl/rc4_pkg.sv
// Shared types, constants and helpers for the RC4 key checker.
package rc4_pkg;

  localparam int         KEY_BYTES = 3;
  localparam logic [7:0] CHAR_LO   = 8'h61;
  localparam logic [7:0] CHAR_HI   = 8'h7A;
  localparam logic [7:0] CHAR_SP   = 8'h20;

  // Top-level phases. DECRYPT is split into its per-byte sub-steps.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHUFFLE,
    ST_DEC_INC,
    ST_DEC_SWAP,
    ST_DEC_RDF,
    ST_DEC_CHK,
    ST_FAIL,
    ST_PASS
  } state_t;

  // Swap sequencer steps. SQ_IDLE doubles as the "read S[i]" cycle.
  typedef enum logic [2:0] {
    SQ_IDLE,
    SQ_WAIT_I,
    SQ_RD_J,
    SQ_WAIT_J,
    SQ_WR_I,
    SQ_WR_J
  } seq_state_t;

  // Key bytes are big-endian: byte 0 is the most significant.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    return key[23:16];
      2'd1:    return key[15:8];
      default: return key[7:0];
    endcase
  endfunction

  // Accepted plaintext: lowercase letters or space.
  function automatic logic is_valid_char(input logic [7:0] b);
    return (b == CHAR_SP) || ((b >= CHAR_LO) && (b <= CHAR_HI));
  endfunction

endpackage

// File: rtl/rc4_key_checker_if.sv
// Memory-side bus of the key checker: S-RAM, encrypted ROM, decrypted RAM.
interface rc4_key_checker_if #(
  parameter int MSG_AW = 5
);
  logic [7:0]        s_addr;
  logic [7:0]        s_wdata;
  logic              s_wren;
  logic [7:0]        s_rdata;
  logic [MSG_AW-1:0] e_addr;
  logic [7:0]        e_rdata;
  logic [MSG_AW-1:0] d_addr;
  logic [7:0]        d_wdata;
  logic              d_wren;

  modport master (
    output s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren,
    input  s_rdata, e_rdata
  );

  modport slave (
    input  s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren,
    output s_rdata, e_rdata
  );
endinterface

// File: rtl/rc4_swap_seq.sv
// Read S[i], compute j' = j + S[i] + addend, read S[j'], write S[i]=S[j'], S[j']=S[i].
// Six cycles per swap; the idle cycle with start high is the S[i] read.
module rc4_swap_seq
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       start,
  input  logic [7:0] i,
  input  logic [7:0] j,
  input  logic [7:0] addend,
  input  logic [7:0] rdata,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  output logic       wren,
  output logic       done,
  output logic [7:0] j_new,
  output logic [7:0] si,
  output logic [7:0] sj
);

  seq_state_t state, next_state;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SQ_IDLE;
    else        state <= next_state;
  end

  // Next-state: fixed read-read-write-write walk, abortable by clear.
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = SQ_IDLE;
    end else begin
      case (state)
        SQ_IDLE:   if (start) next_state = SQ_WAIT_I;
        SQ_WAIT_I: next_state = SQ_RD_J;
        SQ_RD_J:   next_state = SQ_WAIT_J;
        SQ_WAIT_J: next_state = SQ_WR_I;
        SQ_WR_I:   next_state = SQ_WR_J;
        default:   next_state = SQ_IDLE;
      endcase
    end
  end

  // Capture S[i], the new j and S[j] as read data returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      j_new <= '0;
      si    <= '0;
      sj    <= '0;
    end else begin
      if (state == SQ_WAIT_I) begin
        si    <= rdata;
        j_new <= j + rdata + addend;
      end
      if (state == SQ_WAIT_J) sj <= rdata;
    end
  end

  // S-RAM drive per step.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    addr  = i;
    wdata = '0;
    wren  = 1'b0;
    done  = 1'b0;
    case (state)
      SQ_RD_J, SQ_WAIT_J: addr = j_new;
      SQ_WR_I: begin
        addr  = i;
        wdata = sj;
        wren  = 1'b1;
      end
      SQ_WR_J: begin
        addr  = j_new;
        wdata = si;
        wren  = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_key_checker.sv
// RC4 key checker: KSA + PRGA over an external S-RAM, decrypts the message ROM and
// reports a held failure/success verdict. Optional macro RC4_DECRYPT_RAM_EN stores
// each accepted plaintext byte into the decrypted RAM.
module rc4_key_checker
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reset_all,
  input  logic [23:0]               secret_key,
  output logic                      failure,
  output logic                      success,
  rc4_key_checker_if.master         mem
);

  state_t            state, next_state;
  logic [23:0]       key_q;
  logic [7:0]        i, j;
  logic [MSG_AW-1:0] k;
  logic [1:0]        kidx;

  logic       seq_start, seq_wren, seq_done;
  logic [7:0] seq_addr, seq_wdata, seq_j, seq_si, seq_sj, seq_addend;
  logic [7:0] p;
  logic       p_valid, last_byte;

  assign seq_start  = (state == ST_SHUFFLE) || (state == ST_DEC_SWAP);
  assign seq_addend = (state == ST_SHUFFLE) ? key_byte(key_q, kidx) : 8'd0;
  assign p          = mem.s_rdata ^ mem.e_rdata;
  assign p_valid    = is_valid_char(p);
  assign last_byte  = (k == MSG_AW'(MSG_LEN - 1));
  assign mem.e_addr = k;

  rc4_swap_seq u_swap (
    .clk    (clk),
    .reset  (reset),
    .clear  (!reset_all),
    .start  (seq_start),
    .i      (i),
    .j      (j),
    .addend (seq_addend),
    .rdata  (mem.s_rdata),
    .addr   (seq_addr),
    .wdata  (seq_wdata),
    .wren   (seq_wren),
    .done   (seq_done),
    .j_new  (seq_j),
    .si     (seq_si),
    .sj     (seq_sj)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state: dropping reset_all returns to IDLE from anywhere.
  always_comb begin
    next_state = state;
    if (!reset_all) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     next_state = ST_INIT;
        ST_INIT:     if (i == 8'hFF) next_state = ST_SHUFFLE;
        ST_SHUFFLE:  if (seq_done && (i == 8'hFF)) next_state = ST_DEC_INC;
        ST_DEC_INC:  next_state = ST_DEC_SWAP;
        ST_DEC_SWAP: if (seq_done) next_state = ST_DEC_RDF;
        ST_DEC_RDF:  next_state = ST_DEC_CHK;
        ST_DEC_CHK: begin
          if (!p_valid)      next_state = ST_FAIL;
          else if (last_byte) next_state = ST_PASS;
          else               next_state = ST_DEC_INC;
        end
        default:     next_state = state;
      endcase
    end
  end

  // S-RAM drive: INIT fill, sequencer during swaps, keystream lookup in DEC_RDF.
  always_comb begin
    mem.s_addr  = '0;
    mem.s_wdata = '0;
    mem.s_wren  = 1'b0;
    case (state)
      ST_INIT: begin
        mem.s_addr  = i;
        mem.s_wdata = i;
        mem.s_wren  = 1'b1;
      end
      ST_SHUFFLE, ST_DEC_SWAP: begin
        mem.s_addr  = seq_addr;
        mem.s_wdata = seq_wdata;
        mem.s_wren  = seq_wren;
      end
      ST_DEC_RDF: mem.s_addr = seq_si + seq_sj;
      default: ;
    endcase
  end

  // Key latch and i/j/k/key-index bookkeeping per phase.
  // NOTE: S-RAM contents are never reset; INIT rewrites all 256 entries on every run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      kidx  <= '0;
    end else if ((state == ST_IDLE) || !reset_all) begin
      if (state == ST_IDLE) key_q <= secret_key;
      i    <= '0;
      j    <= '0;
      k    <= '0;
      kidx <= '0;
    end else begin
      case (state)
        ST_INIT: i <= i + 8'd1;
        ST_SHUFFLE: if (seq_done) begin
          i    <= i + 8'd1;
          j    <= (i == 8'hFF) ? 8'd0 : seq_j;
          kidx <= (kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx + 2'd1;
        end
        ST_DEC_INC:  i <= i + 8'd1;
        ST_DEC_SWAP: if (seq_done) j <= seq_j;
        ST_DEC_CHK:  if (next_state == ST_DEC_INC) k <= k + 1'b1;
        default: ;
      endcase
    end
  end

  // Verdict levels, registered from the next state so they are never both high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      failure <= 1'b0;
      success <= 1'b0;
    end else begin
      failure <= (next_state == ST_FAIL);
      success <= (next_state == ST_PASS);
    end
  end

`ifdef RC4_DECRYPT_RAM_EN
  logic [MSG_AW-1:0] d_addr_q;
  logic [7:0]        d_wdata_q;
  logic              d_wren_q;

  // Store each accepted plaintext byte at its message index for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_wren_q  <= 1'b0;
    end else begin
      d_wren_q <= reset_all && (state == ST_DEC_CHK) && p_valid;
      if (state == ST_DEC_CHK) begin
        d_addr_q  <= k;
        d_wdata_q <= p;
      end
    end
  end

  assign mem.d_addr  = d_addr_q;
  assign mem.d_wdata = d_wdata_q;
  assign mem.d_wren  = d_wren_q;
`else
  assign mem.d_addr  = '0;
  assign mem.d_wdata = '0;
  assign mem.d_wren  = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_key_checker.sv
// Directed bench for rc4_key_checker with behavioural S-RAM, ROM and decrypted RAM.
module tb_rc4_key_checker;

  localparam int N = 32;
  localparam int T_PASS = 1793 + 9 * N;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reset_all = 1'b0;
  logic [23:0] secret_key = '0;
  logic        failure, success;

  int tests = 0;
  int fails = 0;
  int both_cnt = 0;
  int dwr_cnt = 0;

  rc4_key_checker_if #(.MSG_AW(5)) bus ();

  rc4_key_checker #(.MSG_LEN(N), .MSG_AW(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .reset_all  (reset_all),
    .secret_key (secret_key),
    .failure    (failure),
    .success    (success),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem [256];
  logic [7:0] rom   [N];
  logic [7:0] pt    [N];
  logic [7:0] s_ref [256];
  logic [7:0] ks    [N];
`ifdef RC4_DECRYPT_RAM_EN
  logic [7:0] d_mem [N];
`endif

  // Memory models: registered read, one-cycle latency.
  always @(posedge clk) begin
    if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wdata;
    bus.s_rdata <= s_mem[bus.s_addr];
    bus.e_rdata <= rom[bus.e_addr];
`ifdef RC4_DECRYPT_RAM_EN
    if (bus.d_wren) d_mem[bus.d_addr] <= bus.d_wdata;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ok_char(input logic [7:0] c);
    return (c == 8'h20) || ((c >= 8'h61) && (c <= 8'h7a));
  endfunction

  // Textbook RC4: key schedule, then N keystream bytes into ks[].
  task automatic compute_ks(input logic [23:0] key);
    logic [7:0] kb [3];
    logic [7:0] ii, jj, t;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int n = 0; n < 256; n++) s_ref[n] = n[7:0];
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + s_ref[n] + kb[n % 3];
      t = s_ref[n]; s_ref[n] = s_ref[jj]; s_ref[jj] = t;
    end
    ii = 8'd0;
    jj = 8'd0;
    for (int n = 0; n < N; n++) begin
      ii = ii + 8'd1;
      jj = jj + s_ref[ii];
      t = s_ref[ii]; s_ref[ii] = s_ref[jj]; s_ref[jj] = t;
      t = s_ref[ii] + s_ref[jj];
      ks[n] = s_ref[t];
    end
  endtask

  task automatic load_rom(input logic [255:0] msg, input logic [23:0] key);
    compute_ks(key);
    for (int n = 0; n < N; n++) begin
      pt[n]  = msg[8*(N-1-n) +: 8];
      rom[n] = ks[n] ^ pt[n];
    end
  endtask

  // Expected verdict cycle for decrypting the current ROM with a key.
  task automatic expect_verdict(input logic [23:0] key, output int cyc, output logic pass);
    compute_ks(key);
    pass = 1'b1;
    cyc  = T_PASS;
    for (int n = 0; n < N; n++) begin
      if (!ok_char(ks[n] ^ rom[n])) begin
        pass = 1'b0;
        cyc  = 1793 + 9 * (n + 1);
        break;
      end
    end
  endtask

  // Raise reset_all with a key and count edges until a verdict (bounded).
  task automatic run_key(input logic [23:0] key, output int cyc);
    @(negedge clk);
    secret_key = key;
    reset_all  = 1'b1;
    cyc = -1;
    for (int n = 1; n <= 2600; n++) begin
      @(posedge clk); #1;
      if (failure && success) both_cnt++;
      if (bus.d_wren) dwr_cnt++;
      if (failure || success) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic hold_check(input string tag, input logic exp_f, input logic exp_s);
    repeat (25) @(posedge clk);
    #1;
    check({tag, "_hold_failure"}, failure, exp_f);
    check({tag, "_hold_success"}, success, exp_s);
  endtask

  task automatic release_run(input string tag);
    @(negedge clk);
    reset_all = 1'b0;
    @(posedge clk); #1;
    check({tag, "_rel_failure"}, failure, 1'b0);
    check({tag, "_rel_success"}, success, 1'b0);
    check({tag, "_rel_s_wren"}, bus.s_wren, 1'b0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [255:0] fox;
    logic [255:0] m;
    int           cyc, exp_cyc, wcnt, bad;
    logic         exp_pass;

    fox = "the quick brown fox jumps over a";

    // 1: reset values and IDLE hold.
    repeat (3) @(posedge clk);
    #1;
    check("rst_failure", failure, 1'b0);
    check("rst_success", success, 1'b0);
    check("rst_s_wren", bus.s_wren, 1'b0);
    check("rst_d_wren", bus.d_wren, 1'b0);
    check("rst_s_addr", bus.s_addr, 8'h00);
    check("rst_e_addr", bus.e_addr, 5'h00);
    @(negedge clk);
    reset = 1'b1;
    wcnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus.s_wren || failure || success) wcnt++;
    end
    check("idle_quiet", wcnt, 0);

    // 2: INIT fills S[i]=i in 256 write cycles.
    @(negedge clk);
    secret_key = 24'h000000;
    reset_all  = 1'b1;
    wcnt = 0;
    for (int n = 1; n <= 257; n++) begin
      @(posedge clk); #1;
      if (bus.s_wren) wcnt++;
    end
    check("init_write_cycles", wcnt, 256);
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== n[7:0]) bad++;
    check("init_identity", bad, 0);
    release_run("init");

    // 3: correct key decrypts the fox message.
    load_rom(fox, 24'h000249);
    run_key(24'h000249, cyc);
    check("pass_cycle", cyc, T_PASS);
    check("pass_success", success, 1'b1);
    check("pass_failure", failure, 1'b0);
    hold_check("pass", 1'b0, 1'b1);
`ifdef RC4_DECRYPT_RAM_EN
    bad = 0;
    for (int n = 0; n < N; n++) if (d_mem[n] !== pt[n]) bad++;
    check("dram_plaintext", bad, 0);
`endif
    release_run("pass");

    // 4: wrong key fails at the first invalid byte.
    expect_verdict(24'h000248, exp_cyc, exp_pass);
    run_key(24'h000248, cyc);
    check("wrong_cycle", cyc, exp_cyc);
    check("wrong_failure", failure, !exp_pass);
    check("wrong_success", success, exp_pass);
    hold_check("wrong", !exp_pass, exp_pass);
    release_run("wrong");

    // 5a: 0x60 at k=0 rejected after the first byte.
    m = fox;
    m[255:248] = 8'h60;
    load_rom(m, 24'h000249);
    run_key(24'h000249, cyc);
    check("b60_cycle", cyc, 1793 + 9);
    check("b60_failure", failure, 1'b1);
    check("b60_success", success, 1'b0);
    release_run("b60");

    // 5b: 0x7B at the last byte fails, never passes.
    m = fox;
    m[7:0] = 8'h7B;
    load_rom(m, 24'h000249);
    run_key(24'h000249, cyc);
    check("b7b_cycle", cyc, T_PASS);
    check("b7b_failure", failure, 1'b1);
    check("b7b_success", success, 1'b0);
    hold_check("b7b", 1'b1, 1'b0);
    release_run("b7b");

    // 5c: 0x61 first, 0x7A last, spaces inside: accepted.
    m = fox;
    m[255:248] = 8'h61;
    m[7:0] = 8'h7A;
    load_rom(m, 24'h000249);
    run_key(24'h000249, cyc);
    check("bok_cycle", cyc, T_PASS);
    check("bok_success", success, 1'b1);
    check("bok_failure", failure, 1'b0);
    release_run("bok");

    // 6: abort mid-SHUFFLE (i=100) with another key, then clean restart.
    load_rom(fox, 24'h000249);
    @(negedge clk);
    secret_key = 24'h000248;
    reset_all  = 1'b1;
    repeat (860) @(posedge clk);
    release_run("abort");
    run_key(24'h000249, cyc);
    check("restart_cycle", cyc, T_PASS);
    check("restart_success", success, 1'b1);
    check("restart_failure", failure, 1'b0);

    // Async reset wins mid-run.
    release_run("pre_async");
    @(negedge clk);
    reset_all = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    check("init_active", bus.s_wren, 1'b1);
    reset = 1'b0;
    #1;
    check("async_s_wren", bus.s_wren, 1'b0);
    check("async_s_addr", bus.s_addr, 8'h00);
    @(negedge clk);
    reset_all = 1'b0;
    reset = 1'b1;

    check("never_both", both_cnt, 0);
`ifndef RC4_DECRYPT_RAM_EN
    check("dram_idle", dwr_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
